// File: rtl/rtc_arb_pkg.sv
// Shared types and constants for the RTC bus arbiter: state encoding, requester count,
// select width and the idle/park select code.
package rtc_arb_pkg;

  localparam int N_REQ = 6;
  localparam int SEL_W = 3;

  localparam logic [SEL_W-1:0] PARK_SEL = 3'b000;
  // Reset value of the rotation pointer, chosen so that requester 0 wins the first grant.
  localparam logic [SEL_W-1:0] LAST_RST = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_e;

  function automatic logic [N_REQ-1:0] sel_to_onehot(input logic [SEL_W-1:0] sel);
    sel_to_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << sel;
  endfunction

endpackage

// File: rtl/rtc_rr_pick.sv
// Combinational round-robin picker: returns the first set request bit found by scanning
// last+1, last+2, ... with wrap 5->0, plus a flag saying whether any request was found.
module rtc_rr_pick
  import rtc_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] win,
  output logic             any
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    win  = PARK_SEL;
    any  = 1'b0;
    cand = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = SEL_W'((int'(last) + k) % N_REQ);
      if (!any && req[cand]) begin
        win = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Round-robin owner of the multiplexed RTC bus for six bus-cycle controllers, with a
// guard gap after every release. Define RTC_ARB_TIMEOUT_EN to add the grant watchdog.
module rtc_bus_arbiter
  import rtc_arb_pkg::*;
#(
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 255,
  parameter int TO_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] grant,
  output logic [SEL_W-1:0] seleccion,
  output logic             busy,
  output logic             timeout_err,
  output logic [SEL_W-1:0] err_id
);

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  if (TIMEOUT_CYC >= (1 << TO_W)) begin : g_bad_cfg
    $error("rtc_bus_arbiter: TIMEOUT_CYC must be below 2**TO_W");
  end

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic [SEL_W-1:0] pick_win;
  logic             pick_any;
  logic             expire;

  rtc_rr_pick u_pick (
    .req  (req),
    .last (last_q),
    .win  (pick_win),
    .any  (pick_any)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    last_d  = last_q;
    gap_d   = gap_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_GRANT;
          grant_d = sel_to_onehot(pick_win);
          sel_d   = pick_win;
          last_d  = pick_win;
        end
      end
      ST_GRANT: begin
        // Only the owner's done/req bits matter; sel_q holds the owner index while granted.
        if (done[sel_q] || !req[sel_q] || expire) begin
          grant_d = '0;
          gap_d   = '0;
          state_d = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_W'(GAP_CYC - 1)) state_d = ST_IDLE;
        else                              gap_d   = gap_q + 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registered state is updated with non-blocking assignments only, so every
    // process reads the pre-edge values regardless of evaluation order.
    if (!reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      sel_q   <= PARK_SEL;
      last_q  <= LAST_RST;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      gap_q   <= gap_d;
    end
  end

`ifdef RTC_ARB_TIMEOUT_EN
  logic [TO_W-1:0]  timer_q;
  logic             to_err_q;
  logic [SEL_W-1:0] err_id_q;

  // A done on the expiry cycle is a normal release and suppresses the error.
  assign expire = (state_q == ST_GRANT) && (timer_q == TO_W'(TIMEOUT_CYC - 1)) && !done[sel_q];

  always_ff @(posedge clk) begin
    if (!reset) begin
      timer_q  <= '0;
      to_err_q <= 1'b0;
      err_id_q <= PARK_SEL;
    end else begin
      timer_q  <= (state_q == ST_GRANT) ? timer_q + 1'b1 : '0;
      to_err_q <= expire;
      if (expire) err_id_q <= sel_q;
    end
  end

  assign timeout_err = to_err_q;
  assign err_id      = err_id_q;
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
  assign err_id      = PARK_SEL;
`endif

  assign grant     = grant_q;
  assign seleccion = sel_q;
  assign busy      = |grant_q;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Self-checking bench for rtc_bus_arbiter: a cycle-level ownership model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_rtc_bus_arbiter;

  localparam int GAP = 2;
  localparam int TMO = 10;
`ifdef RTC_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] req = '0;
  logic [5:0] done = '0;
  logic [5:0] grant;
  logic [2:0] seleccion;
  logic       busy;
  logic       timeout_err;
  logic [2:0] err_id;

  int total = 0;
  int bad   = 0;

  rtc_bus_arbiter #(
    .GAP_CYC     (GAP),
    .TIMEOUT_CYC (TMO),
    .TO_W        (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .seleccion   (seleccion),
    .busy        (busy),
    .timeout_err (timeout_err),
    .err_id      (err_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Model: who owns the bus, how long it has held it, how many guard cycles remain.
  typedef struct {
    int owner;   // -1 when nobody owns the bus
    int sel;
    int last;
    int gap;
    int held;
    bit to;
    int errid;
  } model_t;

  function automatic model_t model_step(model_t s, logic rst_n, logic [5:0] rq, logic [5:0] dn);
    model_t n = s;
    bit tmo;
    if (!rst_n) begin
      n.owner = -1; n.sel = 0; n.last = 5; n.gap = 0; n.held = 0; n.to = 0; n.errid = 0;
      return n;
    end
    n.to = 0;
    if (s.owner >= 0) begin
      tmo = TO_EN && (s.held == TMO - 1) && !dn[s.owner];
      if (dn[s.owner] || !rq[s.owner] || tmo) begin
        if (tmo) begin n.to = 1; n.errid = s.owner; end
        n.owner = -1;
        n.gap   = GAP;
      end else begin
        n.held = s.held + 1;
      end
    end else if (s.gap > 0) begin
      n.gap = s.gap - 1;
    end else begin
      for (int k = 1; k <= 6; k++) begin
        int c = (s.last + k) % 6;
        if (n.owner < 0 && rq[c]) begin
          n.owner = c; n.sel = c; n.last = c; n.held = 0;
        end
      end
    end
    return n;
  endfunction

  model_t m;
  bit     m_valid = 1'b0;

  always @(posedge clk) begin
    m <= model_step(m, reset, req, done);
    if (!reset) m_valid <= 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("cyc_grant", 32'(grant), (m.owner >= 0) ? (32'd1 << m.owner) : 32'd0);
      check("cyc_sel", 32'(seleccion), 32'(m.sel));
      check("cyc_busy", 32'(busy), 32'(m.owner >= 0));
      check("cyc_onehot0", 32'($onehot0(grant)), 32'd1);
      check("cyc_tmo_err", 32'(timeout_err), 32'(m.to));
      check("cyc_err_id", 32'(err_id), 32'(m.errid));
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = '0;
    done  = '0;
    repeat (2) nxt();
    reset = 1'b1;
  endtask

  task automatic wait_grant(output int idx);
    idx = -1;
    for (int n = 0; n < 30 && idx < 0; n++) begin
      for (int b = 0; b < 6; b++) if (grant[b]) idx = b;
      if (idx < 0) nxt();
    end
    if (idx < 0) begin
      total++;
      bad++;
      $display("FAIL wait_grant: no grant within 30 cycles at %0t", $time);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "global timeout");
  end

  int idx;
  int order[$];
  int exp_order[7] = '{0, 1, 2, 3, 4, 5, 0};

  initial begin
    // Reset state
    do_reset();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_sel", 32'(seleccion), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tmo_err", 32'(timeout_err), 32'd0);
    check("rst_err_id", 32'(err_id), 32'd0);

    // Single request, 1-cycle latency, release, guard gap
    req = 6'b000100;                       // cycle 0
    nxt();                                 // cycle 1
    check("s1_grant", 32'(grant), 32'h04);
    check("s1_sel", 32'(seleccion), 32'd2);
    check("s1_busy", 32'(busy), 32'd1);
    repeat (4) nxt();                      // cycle 5
    done = 6'b000100;
    req  = 6'b000000;
    nxt();                                 // cycle 6
    done = '0;
    check("s1_release", 32'(grant), 32'd0);
    check("s1_sel_hold", 32'(seleccion), 32'd2);
    req = 6'b000001;
    nxt();                                 // cycle 7
    check("s1_gap7", 32'(grant), 32'd0);
    nxt();                                 // cycle 8
    check("s1_gap8", 32'(grant), 32'd0);
    nxt();                                 // cycle 9
    check("s1_regrant", 32'(grant), 32'h01);
    check("s1_regrant_sel", 32'(seleccion), 32'd0);
    req = '0;
    repeat (4) nxt();

    // All six requesting: rotation order
    do_reset();
    req = 6'b111111;
    for (int i = 0; i < 7; i++) begin
      wait_grant(idx);
      order.push_back(idx);
      repeat (3) nxt();
      done = (idx >= 0) ? (6'b000001 << idx) : 6'b000000;
      nxt();
      done = '0;
    end
    req = '0;
    for (int i = 0; i < 7; i++) check("rr_order", 32'(order[i]), 32'(exp_order[i]));
    repeat (4) nxt();

    // Non-owner done ignored, owner withdraws, select holds through gap
    req = 6'b001010;
    wait_grant(idx);
    check("s3_owner", 32'(idx), 32'd1);
    done = 6'b001000;
    nxt();
    done = '0;
    nxt();
    check("s3_ignore_done", 32'(grant), 32'h02);
    req = 6'b001000;
    nxt();
    check("s3_withdraw", 32'(grant), 32'd0);
    check("s3_sel_gap_a", 32'(seleccion), 32'd1);
    nxt();
    check("s3_sel_gap_b", 32'(seleccion), 32'd1);
    nxt();
    check("s3_sel_idle", 32'(seleccion), 32'd1);
    nxt();
    check("s3_next_grant", 32'(grant), 32'h08);
    check("s3_next_sel", 32'(seleccion), 32'd3);
    req = '0;
    repeat (4) nxt();

    // Hung owner 4 with requester 5 pending
    req = 6'b110000;
    wait_grant(idx);
    check("s4_owner", 32'(idx), 32'd4);
`ifdef RTC_ARB_TIMEOUT_EN
    repeat (9) nxt();
    check("s4_last_held", 32'(grant), 32'h10);
    check("s4_no_err_yet", 32'(timeout_err), 32'd0);
    nxt();
    check("s4_forced", 32'(grant), 32'd0);
    check("s4_err_pulse", 32'(timeout_err), 32'd1);
    check("s4_err_id", 32'(err_id), 32'd4);
    nxt();
    check("s4_err_once", 32'(timeout_err), 32'd0);
    check("s4_err_id_hold", 32'(err_id), 32'd4);
    nxt();
    nxt();
    check("s4_next5", 32'(grant), 32'h20);
    check("s4_next5_sel", 32'(seleccion), 32'd5);
`else
    repeat (12) nxt();
    check("s4_still_held", 32'(grant), 32'h10);
    check("s4_no_err", 32'(timeout_err), 32'd0);
    req = 6'b100000;
    nxt();
    check("s4_withdraw", 32'(grant), 32'd0);
    repeat (3) nxt();
    check("s4_next5", 32'(grant), 32'h20);
`endif
    req = '0;
    repeat (4) nxt();

    // done on the expiry cycle wins over the watchdog
    req = 6'b010000;
    wait_grant(idx);
    check("s5_owner", 32'(idx), 32'd4);
    repeat (9) nxt();
    done = 6'b010000;
    nxt();
    done = '0;
    req  = '0;
    check("s5_release", 32'(grant), 32'd0);
    check("s5_no_err", 32'(timeout_err), 32'd0);
`ifdef RTC_ARB_TIMEOUT_EN
    check("s5_err_id_kept", 32'(err_id), 32'd4);
`endif
    nxt();
    check("s5_no_err_late", 32'(timeout_err), 32'd0);
    repeat (3) nxt();

    // Reset mid-grant, then requester 0 wins first
    req = 6'b001000;
    wait_grant(idx);
    check("s6_owner", 32'(idx), 32'd3);
    nxt();
    nxt();
    reset = 1'b0;
    nxt();
    check("s6_rst_grant", 32'(grant), 32'd0);
    check("s6_rst_sel", 32'(seleccion), 32'd0);
    check("s6_rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    req   = 6'b001001;
    nxt();
    check("s6_first0", 32'(grant), 32'h01);
    check("s6_first0_sel", 32'(seleccion), 32'd0);
    req = '0;
    repeat (4) nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rtc_bus_arbiter.md
Name: rtc_bus_arbiter

Overview:
Scheduler that shares the multiplexed RTC bus (ad/rd/cs/wr/ADout) among six bus-cycle controllers. It drives the 3-bit select of the RTC control-word multiplexer.
- Requester i maps to select code i (0..5).
- Requesters ask with req, own the bus while granted, and release it with a done pulse.
- Grants are round-robin. Every ownership is followed by a guard gap. An optional watchdog reclaims a hung grant.

Parameters:
N_REQ, 6, number of requesters; fixed at 6 (select codes 0..5; codes 6/7 never driven)
GAP_CYC, 2, idle guard cycles after each release before the next grant (0 allowed)
TIMEOUT_CYC, 255, max cycles a grant may be held before forced release (watchdog build only)
TO_W, 8, watchdog counter width; must satisfy TIMEOUT_CYC < 2**TO_W

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
req  in  6  request per controller, level; held until done or granted
done  in  6  release pulse per controller; only owner's bit is honoured
grant  out  6  one-hot ownership, registered; all-zero when no owner
seleccion  out  3  registered select to RTC control mux; index of current/last owner
busy  out  1  high while any grant asserted
timeout_err  out  1  one-cycle pulse on watchdog release
err_id  out  3  index of requester that timed out; holds until next timeout

Behaviour:
- Reset (reset=0 at a clk edge) applies the following; it overrides everything, including mid-grant:
  - grant=0, seleccion=3'b000, busy=0, timeout_err=0, err_id=0.
  - Round-robin pointer last=5, so requester 0 wins first; state=IDLE.
- State IDLE:
  - When req!=0, pick the first set bit scanning last+1, last+2, ... with wrap 5->0.
  - Next edge: grant[w]=1, seleccion=w, busy=1, last=w, timer=0, state=GRANT.
  - Latency is 1 cycle from req sampled to grant visible.
- State GRANT (owner w):
  - Timer increments each cycle.
  - Release when done[w]=1, or when req[w]=0 (owner withdrew).
  - On release, next edge: grant=0, busy=0, state=GAP (or IDLE if GAP_CYC=0).
  - done/req changes of non-owners are ignored.
  - If done[w] and a watchdog expiry coincide, done wins and there is no timeout_err.
- State GAP:
  - grant=0 and seleccion holds w, so the owner's strobe-deassert word stays on the bus.
  - Counts GAP_CYC cycles, then goes to IDLE.
  - Requests arriving during GAP wait; they are arbitrated in IDLE.
- seleccion changes only on a new grant; never glitches between grants.
- A requester holding req continuously after done re-competes; the rotation guarantees the other active requesters are served first. Starvation bound: 5 × (max grant + GAP_CYC + 1) cycles.
- grant is always one-hot or zero; no two requesters own the bus in the same cycle.

Optional Feature:
RTC_ARB_TIMEOUT_EN
- Defined:
  - In GRANT, when timer==TIMEOUT_CYC-1 and done[w]=0, the next edge forces release as for done.
  - The same edge pulses timeout_err=1 for exactly one cycle and loads err_id=w.
- Undefined:
  - No timer logic; a grant holds until done or req withdrawal.
  - timeout_err is tied 0 and err_id is tied 0.
  - TIMEOUT_CYC and TO_W are unused.

Decomposition:
- Package rtc_arb_pkg holds:
  - State encoding IDLE/GRANT/GAP (2-bit).
  - N_REQ=6 and SEL_W=3 constants.
  - The idle/park select constant 3'b000.
- One natural sub-module: rtc_rr_pick.
  - Combinational round-robin picker with inputs req[5:0] and last[2:0], outputs win[2:0] and any.
  - It is reusable and unit-testable alone.
- The arbiter FSM, gap counter and watchdog stay in rtc_bus_arbiter.

Test Plan:
- Reset then req=6'b000100 at cycle 0 -> cycle 1 grant=6'b000100, seleccion=2, busy=1; done[2] pulse at cycle 5 -> cycle 6 grant=0; with GAP_CYC=2 the next grant is no earlier than cycle 9.
- req=6'b111111 held, each owner pulses done 3 cycles after grant -> grant order 0,1,2,3,4,5,0; never two bits set.
- Owner 1 granted, done[3] pulsed (non-owner) -> no change; then req[1] dropped -> release next edge, seleccion stays 1 through the gap.
- RTC_ARB_TIMEOUT_EN, TIMEOUT_CYC=10: requester 4 granted, never done -> after 10 grant cycles grant=0, timeout_err=1 for exactly 1 cycle, err_id=4; then requester 5 (pending) granted after the gap.
- Same as the previous scenario but done[4] arrives on the expiry cycle -> normal release, timeout_err stays 0.
- reset=0 asserted mid-GRANT (owner 3) -> next edge grant=0, seleccion=0, busy=0; after reset, req=6'b001001 -> requester 0 granted first.
